simple_dual_port_ram: RTL and testbench
=======================================

SIMPLE_DUAL_PORT_RAM -- requirements
Module: simple_dual_port_ram

Interface
- REQ-001 Reset is asynchronous and active-low; the design uses one clock, named clk, and the reset port is named rst.
- REQ-002 Parameters live on interface sdpram_if, in positional order:
  - DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
  - MEM_DEPTH, default 1024, number of words.
  - OUT_REG, default 0, adds one output pipeline register when 1.
- REQ-003 sdpram_if SHALL derive:
  - ADDR_WIDTH = $clog2(MEM_DEPTH).
  - STRB_WIDTH = DATA_WIDTH/8.
- REQ-004 Module ports (direction, width, meaning):
  - clk  input  1  clock.
  - rst  input  1  async active-low reset.
  - ifp  interface sdpram_if  -  all data and control signals, via modport ram.
- REQ-005 sdpram_if signals (direction relative to the RAM):
  - wena  in  STRB_WIDTH  per-byte write enable, port A.
  - addra  in  ADDR_WIDTH  write address.
  - dina  in  DATA_WIDTH  write data.
  - renb  in  1  read enable, port B.
  - addrb  in  ADDR_WIDTH  read address.
  - doutb  out  DATA_WIDTH  read data.
- REQ-006 sdpram_if SHALL provide modports ram and tb with mirrored directions.

Function
- REQ-007 Write: on each rising clk, for every bit i where wena[i]=1, byte i of mem[addra] SHALL take dina[8i+7:8i]; bytes whose enable is 0 SHALL keep their value.
- REQ-008 wena of all zeros SHALL leave memory unchanged.
- REQ-009 Read with OUT_REG=0: when renb=1 at a rising clk, doutb SHALL present mem[addrb] from that edge onward (1-cycle latency).
- REQ-010 Read with OUT_REG=1: the data of REQ-009 SHALL appear one cycle later (2-cycle latency); the extra stage SHALL advance only when its input stage was loaded.
- REQ-011 When renb=0, doutb SHALL hold its previous value.
- REQ-012 An address >= MEM_DEPTH SHALL be ignored for writes; a read of such an address SHALL return all zeros.
- REQ-013 Same-address write and read in one cycle SHALL be read-first: doutb returns the pre-write contents, unless REQ-019 is enabled.
- REQ-014 Memory contents SHALL NOT be initialised or reset; reading a never-written word returns X in simulation.
- REQ-015 Ports A and B SHALL be fully independent; there are no stalls and no backpressure.

Reset
- REQ-016 While rst=0, doutb and any output-pipeline register SHALL be 0, asynchronously.
- REQ-017 Reset SHALL NOT alter memory contents; writes are ignored while rst=0.
- REQ-018 After rst deasserts, the first read completes with the latency of REQ-009/REQ-010.

Configuration
- REQ-019 Macro SDPRAM_WRITE_FIRST_EN, when defined, on a same-address collision doutb SHALL return:
  - the newly written bytes where wena=1;
  - the old bytes elsewhere.
- REQ-020 When SDPRAM_WRITE_FIRST_EN is undefined, collisions SHALL be read-first (REQ-013).

Structure
- REQ-021 Package sdpram_pkg SHALL hold:
  - default constants DEF_DATA_WIDTH=32, DEF_MEM_DEPTH=1024, DEF_OUT_REG=0;
  - a function computing STRB_WIDTH.
- REQ-022 The interface sdpram_if SHALL be in its own file.
- REQ-023 Sub-module sdpram_byte_merge SHALL compute the byte-masked write and forward word; it is used for writes and for REQ-019.
- REQ-024 The memory array SHALL be inferable as block RAM.

Verification
- REQ-025 Full write then read: wena=4'hF, addra=10'h005, dina=32'hDEADBEEF; next cycle renb=1, addrb=10'h005 -> doutb=32'hDEADBEEF after 1 edge.
- REQ-026 Byte strobe:
  - write 32'h11223344 to address 7 with wena=F;
  - then write 32'hAABBCCDD to address 7 with wena=4'b0101;
  - then read address 7 -> 32'h11BB33DD.
- REQ-027 Collision: address 3 holds 32'h0; write 32'hFFFFFFFF and read address 3 in the same cycle:
  - without the macro -> doutb=0;
  - with SDPRAM_WRITE_FIRST_EN -> doutb=32'hFFFFFFFF.
- REQ-028 renb hold: after reading 32'hCAFE0001, set renb=0 and change addrb -> doutb stays 32'hCAFE0001.
- REQ-029 Reset mid-operation: assert rst=0 between clock edges -> doutb=0 immediately; previously written data is still readable after release.
- REQ-030 Random test: 100 cycles of random wena/addra/dina and random addrb with renb=1, checked against a reference model with 4-state compare -> zero mismatches.

Source files
------------

// File: rtl/sdpram_pkg.sv
// Shared constants and helpers for the simple dual-port RAM.
// Default geometry, byte width and the strobe-width calculation used by the
// interface, the top level and the byte-merge helper.
package sdpram_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MEM_DEPTH  = 1024;
  localparam int unsigned DEF_OUT_REG    = 0;
  localparam int unsigned BYTE_W         = 8;

  // One write strobe per byte lane.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/sdpram_if.sv
// Bundle of all RAM data/control signals.
// Parameters (positional): DATA_WIDTH, MEM_DEPTH, OUT_REG.
// Signals: wena/addra/dina (write port A), renb/addrb (read port B), doutb.
// Modports: ram (RAM side) and tb (driver side, mirrored directions).
interface sdpram_if
  import sdpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned OUT_REG    = DEF_OUT_REG
);

  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  logic [STRB_WIDTH-1:0] wena;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  renb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;

  modport ram (
    input  wena,
    input  addra,
    input  dina,
    input  renb,
    input  addrb,
    output doutb
  );

  modport tb (
    output wena,
    output addra,
    output dina,
    output renb,
    output addrb,
    input  doutb
  );

endinterface

// File: rtl/sdpram_byte_merge.sv
// Byte-lane merge helper.
// Gates the per-byte strobes with a qualifying enable (be_c) and produces a
// word whose enabled lanes come from new_word and the rest from old_word
// (word_c). Used both to form the masked write and the write-first forward.
// Ports: old_word, new_word, strb, en in; be_c, word_c out (combinational).
module sdpram_byte_merge
  import sdpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]             old_word,
  input  logic [DATA_WIDTH-1:0]             new_word,
  input  logic [strb_width(DATA_WIDTH)-1:0] strb,
  input  logic                              en,
  output logic [strb_width(DATA_WIDTH)-1:0] be_c,
  output logic [DATA_WIDTH-1:0]             word_c
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  // Lane select: enabled lanes take the new byte, others keep the old one.
  always_comb begin
    be_c   = strb & {STRB_WIDTH{en}};
    word_c = old_word;
    for (int b = 0; b < int'(STRB_WIDTH); b++) begin
      if (be_c[b]) begin
        word_c[b*BYTE_W +: BYTE_W] = new_word[b*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: byte-strobed write port A, registered read port B.
// Ports: clk, rst (async active-low, clears only the read path),
//        ifp (sdpram_if.ram: wena, addra, dina, renb, addrb, doutb).
// Read latency is 1 cycle, or 2 when the interface sets OUT_REG=1.
// Same-address collisions are read-first by default; define
// SDPRAM_WRITE_FIRST_EN to forward the newly written bytes instead.
module simple_dual_port_ram
  import sdpram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  sdpram_if.ram ifp
);

  localparam int unsigned DATA_WIDTH = ifp.DATA_WIDTH;
  localparam int unsigned MEM_DEPTH  = ifp.MEM_DEPTH;
  localparam int unsigned OUT_REG    = ifp.OUT_REG;
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  // Storage: no reset, no init, so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_valid_c;
  logic                  rd_valid_c;
  logic [STRB_WIDTH-1:0] wr_be_c;
  logic [DATA_WIDTH-1:0] wr_word_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [DATA_WIDTH-1:0] rd_q;

  // Out-of-range addresses are dropped; writes are blocked during reset.
  assign wr_valid_c = rst && (32'(ifp.addra) < MEM_DEPTH);
  assign rd_valid_c = (32'(ifp.addrb) < MEM_DEPTH);

  // Masked write lanes; only lanes with be_c set are stored.
  sdpram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_merge (
    .old_word ({DATA_WIDTH{1'b0}}),
    .new_word (ifp.dina),
    .strb     (ifp.wena),
    .en       (wr_valid_c),
    .be_c     (wr_be_c),
    .word_c   (wr_word_c)
  );

  // Per-byte write enables keep the array in byte-write RAM form.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(STRB_WIDTH); b++) begin
      if (wr_be_c[b]) begin
        mem[ifp.addra][b*BYTE_W +: BYTE_W] <= wr_word_c[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Pre-write contents of the read address; zeros when out of range.
  always_comb begin
    rd_word_c = '0;
    if (rd_valid_c) begin
      rd_word_c = mem[ifp.addrb];
    end
  end

`ifdef SDPRAM_WRITE_FIRST_EN
  logic [STRB_WIDTH-1:0] fwd_be_c;
  logic [DATA_WIDTH-1:0] fwd_word_c;

  // Collision forward: new bytes where written, old bytes elsewhere.
  sdpram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fwd_merge (
    .old_word (rd_word_c),
    .new_word (ifp.dina),
    .strb     (ifp.wena),
    .en       (wr_valid_c && (ifp.addra == ifp.addrb)),
    .be_c     (fwd_be_c),
    .word_c   (fwd_word_c)
  );

  assign rd_data_c = (|fwd_be_c) ? fwd_word_c : rd_word_c;
`else
  // Read-first: the register samples the array before the write lands.
  assign rd_data_c = rd_word_c;
`endif

  // First read stage; holds when renb is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (ifp.renb) begin
      rd_q <= rd_data_c;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rd_vld_q;
      logic [DATA_WIDTH-1:0] out_q;

      // Second stage only advances after the first stage was loaded.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_vld_q <= 1'b0;
          out_q    <= '0;
        end else begin
          rd_vld_q <= ifp.renb;
          if (rd_vld_q) begin
            out_q <= rd_q;
          end
        end
      end

      assign ifp.doutb = out_q;
    end else begin : g_no_out_reg
      assign ifp.doutb = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Self-checking bench for simple_dual_port_ram (32-bit x 1024, OUT_REG=0).
// Reads push the model's expected word onto a queue; the word is popped and
// compared against doutb one edge later.
module tb_simple_dual_port_ram;

  logic clk;
  logic rst;

  sdpram_if #(32, 1024, 0) ifp ();

  simple_dual_port_ram dut (
    .clk (clk),
    .rst (rst),
    .ifp (ifp.ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [1024];
  logic [31:0] exp_q [$];
  int          vectors;
  int          miscompares;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // One clock: drive, update model, then check any read that completed.
  task automatic cycle(input string name, input logic [3:0] wena,
                       input logic [9:0] addra, input logic [31:0] dina,
                       input logic renb, input logic [9:0] addrb);
    logic [31:0] exp_w;
    logic [31:0] got;
    ifp.wena  = wena;
    ifp.addra = addra;
    ifp.dina  = dina;
    ifp.renb  = renb;
    ifp.addrb = addrb;
    if (renb) begin
      exp_w = model[addrb];
`ifdef SDPRAM_WRITE_FIRST_EN
      if (rst && (addra == addrb)) exp_w = lane_merge(exp_w, dina, wena);
`endif
      exp_q.push_back(exp_w);
    end
    if (rst) model[addra] = lane_merge(model[addra], dina, wena);
    @(posedge clk);
    #1;
    if (renb) begin
      got = ifp.doutb;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: got %h, scoreboard empty", name, got);
      end else begin
        exp_w = exp_q.pop_front();
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", name, got, exp_w);
        end
      end
    end
  endtask

  task automatic idle();
    cycle("idle", 4'h0, 10'h0, 32'h0, 1'b0, 10'h0);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (ifp.doutb !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_dout: got %h expected %h", ifp.doutb, 32'h0);
    end
    idle();
    idle();
    rst = 1'b1;
    vectors++;
    if (ifp.doutb !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", ifp.doutb, 32'h0);
    end
  endtask

  task automatic test_full_write();
    cycle("full_wr", 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 10'h0);
    cycle("full_rd", 4'h0, 10'h0, 32'h0, 1'b1, 10'h005);
  endtask

  task automatic test_byte_strobe();
    cycle("strb_wr1", 4'hF, 10'h007, 32'h11223344, 1'b0, 10'h0);
    cycle("strb_wr2", 4'b0101, 10'h007, 32'hAABBCCDD, 1'b0, 10'h0);
    cycle("strb_rd", 4'h0, 10'h0, 32'h0, 1'b1, 10'h007);
    vectors++;
    if (ifp.doutb !== 32'h11BB33DD) begin
      miscompares++;
      $display("FAIL strb_const: got %h expected %h", ifp.doutb, 32'h11BB33DD);
    end
  endtask

  task automatic test_zero_strobe();
    cycle("zero_wr", 4'h0, 10'h005, 32'h0BADF00D, 1'b0, 10'h0);
    cycle("zero_rd", 4'h0, 10'h0, 32'h0, 1'b1, 10'h005);
  endtask

  task automatic test_collision();
    cycle("coll_init", 4'hF, 10'h003, 32'h0, 1'b0, 10'h0);
    cycle("collision", 4'hF, 10'h003, 32'hFFFFFFFF, 1'b1, 10'h003);
    cycle("coll_after", 4'h0, 10'h0, 32'h0, 1'b1, 10'h003);
    cycle("coll_part_init", 4'hF, 10'h004, 32'h12345678, 1'b0, 10'h0);
    cycle("coll_partial", 4'b0110, 10'h004, 32'hAABBCCDD, 1'b1, 10'h004);
  endtask

  task automatic test_hold();
    cycle("hold_wr", 4'hF, 10'h020, 32'hCAFE0001, 1'b0, 10'h0);
    cycle("hold_rd", 4'h0, 10'h0, 32'h0, 1'b1, 10'h020);
    for (int i = 0; i < 3; i++) begin
      cycle("hold_idle", 4'hF, 10'h020, 32'h5555_0000 + 32'(i), 1'b0, 10'(i + 1));
      vectors++;
      if (ifp.doutb !== 32'hCAFE0001) begin
        miscompares++;
        $display("FAIL hold_%0d: got %h expected %h", i, ifp.doutb, 32'hCAFE0001);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle("mid_rd", 4'h0, 10'h0, 32'h0, 1'b1, 10'h007);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (ifp.doutb !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_dout: got %h expected %h", ifp.doutb, 32'h0);
    end
    // Write attempted during reset must not land.
    cycle("mid_wr_blocked", 4'hF, 10'h007, 32'hFFFF0000, 1'b0, 10'h0);
    rst = 1'b1;
    vectors++;
    if (ifp.doutb !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_hold: got %h expected %h", ifp.doutb, 32'h0);
    end
    cycle("mid_after_rd", 4'h0, 10'h0, 32'h0, 1'b1, 10'h007);
    cycle("mid_after_rd2", 4'h0, 10'h0, 32'h0, 1'b1, 10'h005);
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) begin
      cycle("rnd_init", 4'hF, 10'(a), $urandom, 1'b0, 10'h0);
    end
    for (int i = 0; i < 100; i++) begin
      cycle("random", 4'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
            $urandom, 1'b1, 10'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    ifp.wena    = '0;
    ifp.addra   = '0;
    ifp.dina    = '0;
    ifp.renb    = 1'b0;
    ifp.addrb   = '0;
    test_reset();
    test_full_write();
    test_byte_strobe();
    test_zero_strobe();
    test_collision();
    test_hold();
    test_reset_mid();
    test_random();
    idle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
